fram_stream_reader: RTL and testbench
=====================================

# fram_stream_reader

Reader for the filtered-output RAM. After the FIR filter has written all NUM_SAMPLES results, this block walks the RAM from address 0 to NUM_SAMPLES-1 and streams each 32-bit sample out on a valid/ready interface, for example to the FFT front end. It hides the RAM read latency behind a small prefetch FIFO, so sustained throughput is one sample per cycle and backpressure loses or duplicates nothing.

## Interface

Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 32, sample width (IEEE-754 single, passed through untouched)
- NUM_SAMPLES, 1000, samples per frame (≤ 2**ADDR_W)
- RD_LAT, 1, RAM read latency in cycles (1 or 2)
- FIFO_DEPTH, 4, prefetch depth; must be ≥ RD_LAT+2

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to stream one frame
- src_ready  in  1  level; high once the filter has finished writing the RAM
- ram_addr  out  ADDR_W  RAM read address (registered)
- ram_dout  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_addr
- m_data  out  DATA_W  sample
- m_valid  out  1  sample valid
- m_ready  in  1  sink accepts; transfer happens when m_valid&&m_ready
- m_last  out  1  high with the final sample (index NUM_SAMPLES-1)
- busy  out  1  frame in progress
- done  out  1  frame complete; held until next accepted start or reset

## Operation

- FSM states:
  - IDLE: start → WAIT_SRC.
  - WAIT_SRC: src_ready → STREAM.
  - STREAM: issues reads until NUM_SAMPLES addresses have been issued → DRAIN.
  - DRAIN: waits for the final handshake → DONE.
  - DONE: start → WAIT_SRC.
- start is ignored in WAIT_SRC, STREAM and DRAIN.
- Read issue rule: issue in STREAM when issued_cnt < NUM_SAMPLES and fifo_count + inflight < FIFO_DEPTH.
  - inflight is the number of reads within RD_LAT of issue, tracked by an RD_LAT-deep valid shift register.
  - The FIFO can never overflow; an overflow is a design error.
- ram_addr = issued_cnt at issue. It never exceeds NUM_SAMPLES-1 and never wraps. It holds its value when no read is issued.
- Return data is pushed into the FIFO on the cycle its shift-register bit emerges.
- m_data/m_valid come from the FIFO head; m_valid = fifo non-empty.
- A pop occurs on handshake; push and pop in the same cycle leave fifo_count unchanged.
- sent_cnt counts handshakes. m_last = m_valid && (sent_cnt == NUM_SAMPLES-1).
- busy is high in WAIT_SRC, STREAM and DRAIN. done is high only in DONE.
- If src_ready drops during STREAM or DRAIN, the frame continues; it is sampled only in WAIT_SRC.
- Reset values: state IDLE, ram_addr 0, m_valid 0, m_last 0, m_data 0, busy 0, done 0, all counters 0, FIFO empty, inflight 0.
- Reset mid-frame: in-flight reads are discarded and the next frame starts again at address 0.

## Timing

- start high in cycle c with src_ready high:
  - busy=1 and first read (ram_addr=0) in c+1
  - m_valid=1 with sample 0 in c+2+RD_LAT
- m_ready held high: one sample per cycle, no bubbles. Sample i appears in c+2+RD_LAT+i. m_last appears in c+1+RD_LAT+NUM_SAMPLES.
- done=1 and busy=0 the cycle after the last handshake.
- m_ready low: m_data and m_valid stay stable. At most FIFO_DEPTH reads are outstanding or buffered.
- When m_ready reasserts, the head transfers the same cycle; full rate resumes with no bubble.
- start arriving in DONE: done clears in the next cycle and the next frame follows the same timing.

## Structure

- Package fram_pkg holds:
  - ADDR_W, DATA_W, NUM_SAMPLES defaults (shared with the filter and the RAM wrapper)
  - the reader FSM state enum
- Sub-module sample_fifo (parameters DEPTH and WIDTH): synchronous FIFO exposing count, full, empty, and a first-word-fall-through head.
- The top level contains the FSM, issue logic, inflight shift register and counters.

## Test plan

The bench uses a RAM model with RD_LAT=1 and contents mem[i]=32'h3F80_0000+i.

1. Full frame: src_ready=1, pulse start, m_ready=1.
   - 1000 beats, data mem[0..999] in order.
   - First m_valid at start+3 cycles; m_last only on beat 999.
   - done one cycle after beat 999.
2. Backpressure: m_ready follows the pattern 1,0,0,1,1,0 repeated.
   - No loss and no duplicates.
   - ram_addr ≤ 999; fifo_count+inflight ≤ 4 at all times.
   - m_data stable while stalled.
3. Stall at start: m_ready=0 for 20 cycles after start.
   - Exactly 4 reads issued (addresses 0–3).
   - Then full rate with no bubble once m_ready=1.
4. Source gating: start with src_ready=0.
   - busy=1, no reads issued.
   - src_ready rising at cycle 50 → ram_addr=0 the next cycle.
5. Reset mid-frame: assert rst after beat 500.
   - Next cycle m_valid=0, busy=0, done=0.
   - A following start streams again from mem[0].
6. Start handling:
   - start during STREAM → ignored, frame length still 1000.
   - start while done=1 → second identical frame, done cleared one cycle after start.

Source files
------------

// File: rtl/fram_pkg.sv
// Shared constants for the filtered-output RAM path and the reader FSM states.
package fram_pkg;

  localparam int FRAM_ADDR_W      = 10;
  localparam int FRAM_DATA_W      = 32;
  localparam int FRAM_NUM_SAMPLES = 1000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SRC = 3'd1,
    ST_STREAM   = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } rd_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head.
// A push is dropped when full and a pop is ignored when empty. The reader
// never reaches either case, so these guards only protect the pointers.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; storage clears so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fram_stream_reader.sv
// Walks the filtered-output RAM from address 0 to NUM_SAMPLES-1 and streams
// each sample on a valid/ready port, prefetching to hide the RAM latency.
//
// Handshake: m_valid is the FIFO non-empty flag; a beat transfers in every
// cycle where m_valid && m_ready, and while m_ready is low the head
// (m_data/m_valid/m_last) holds. m_valid never drops without a transfer.
//
// Read pipeline: a read decided in cycle t loads ram_addr at t+1. pipe_q[0]
// qualifies ram_addr, and pipe_q[RD_LAT] qualifies ram_dout RD_LAT cycles
// later, which is the cycle the sample is pushed. The first read is issued
// in the same cycle a start is accepted with src_ready already high, so
// ram_addr=0 appears the cycle after start.
module fram_stream_reader
  import fram_pkg::*;
#(
  parameter int ADDR_W      = FRAM_ADDR_W,
  parameter int DATA_W      = FRAM_DATA_W,
  parameter int NUM_SAMPLES = FRAM_NUM_SAMPLES,
  parameter int RD_LAT      = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          src_ready,
  output logic [ADDR_W-1:0]                             ram_addr,
  input  logic [DATA_W-1:0]                             ram_dout,
  output logic [DATA_W-1:0]                             m_data,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic                                          m_last,
  output logic                                          busy,
  output logic                                          done,
  output rd_state_e                                     dbg_state_o,
  output logic [$clog2(FIFO_DEPTH+RD_LAT+2)-1:0]        dbg_outstanding_o
);

  localparam int SCNT_W = ADDR_W + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LAT + 2);
  localparam logic [SCNT_W-1:0] N_ALL  = SCNT_W'(NUM_SAMPLES);
  localparam logic [SCNT_W-1:0] N_LAST = SCNT_W'(NUM_SAMPLES - 1);

  rd_state_e         state_q, state_d;
  logic [SCNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [SCNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [RD_LAT:0]   pipe_q;
  logic [OCC_W-1:0]  inflight, occupancy;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty;
  logic              issue_req, issue, handshake, last_hs, frame_end;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pipe_q[RD_LAT]),
    .push_data_i (ram_dout),
    .pop_i       (handshake),
    .head_o      (m_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign m_valid   = !fifo_empty;
  assign handshake = m_valid && m_ready;
  assign last_hs   = handshake && (sent_cnt_q == N_LAST);
  assign frame_end = (state_q == ST_DRAIN) && last_hs;
  assign m_last    = m_valid && (sent_cnt_q == N_LAST);
  assign busy      = (state_q == ST_WAIT_SRC) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign ram_addr  = ram_addr_q;

  assign dbg_state_o       = state_q;
  assign dbg_outstanding_o = occupancy;

  // Reads still in the RAM pipeline plus samples already buffered.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + OCC_W'(pipe_q[i]);
    occupancy = inflight + OCC_W'(fifo_count);
  end

  // Issue decision and next state; src_ready only matters until streaming begins.
  always_comb begin
    issue_req = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_IDLE: begin
        issue_req = start && src_ready;
        if (start) state_d = ST_WAIT_SRC;
      end
      ST_WAIT_SRC: begin
        issue_req = src_ready;
        if (src_ready) state_d = (issued_cnt_d == N_ALL) ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        issue_req = 1'b1;
        if (issued_cnt_d == N_ALL) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_hs) state_d = ST_DONE;
      end
      ST_DONE: begin
        issue_req = start && src_ready;
        if (start) state_d = ST_WAIT_SRC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue = issue_req && (issued_cnt_q < N_ALL) &&
                 (occupancy < OCC_W'(FIFO_DEPTH)) && !fifo_full;

  // Frame counters; both clear on the final handshake so DONE is ready for the next start.
  always_comb begin
    issued_cnt_d = issued_cnt_q;
    sent_cnt_d   = sent_cnt_q;
    if (frame_end) begin
      issued_cnt_d = '0;
      sent_cnt_d   = '0;
    end else begin
      if (issue)     issued_cnt_d = issued_cnt_q + SCNT_W'(1);
      if (handshake) sent_cnt_d   = sent_cnt_q + SCNT_W'(1);
    end
  end

  // State, counters, address and read-valid pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issued_cnt_q <= '0;
      sent_cnt_q   <= '0;
      ram_addr_q   <= '0;
      pipe_q       <= '0;
    end else begin
      state_q      <= state_d;
      issued_cnt_q <= issued_cnt_d;
      sent_cnt_q   <= sent_cnt_d;
      if (issue) ram_addr_q <= issued_cnt_q[ADDR_W-1:0];
      pipe_q       <= {pipe_q[RD_LAT-1:0], issue};
    end
  end

endmodule

// File: tb/tb_fram_stream_reader.sv
// Directed bench for fram_stream_reader with a one-cycle-latency RAM model
// holding mem[i] = 32'h3F80_0000 + i.
module tb_fram_stream_reader;
  import fram_pkg::*;

  localparam int N = 1000;
  localparam logic [31:0] BASE = 32'h3F80_0000;

  logic        clk = 1'b0;
  logic        rst, start, src_ready, m_ready;
  logic [9:0]  ram_addr;
  logic [31:0] ram_dout = '0;
  logic [31:0] m_data;
  logic        m_valid, m_last, busy, done;
  rd_state_e   dbg_state;
  logic [2:0]  dbg_outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  // RAM model, RD_LAT = 1
  always @(posedge clk) ram_dout <= BASE + 32'(ram_addr);

  fram_stream_reader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .src_ready         (src_ready),
    .ram_addr          (ram_addr),
    .ram_dout          (ram_dout),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_last            (m_last),
    .busy              (busy),
    .done              (done),
    .dbg_state_o       (dbg_state),
    .dbg_outstanding_o (dbg_outstanding)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start with src_ready high and check the first-read / first-sample timing.
  // Leaves the bench in cycle c+3, where sample 0 is at the head.
  task automatic start_head(input logic rdy);
    start = 1'b1; src_ready = 1'b1; m_ready = rdy;
    tick();                                   // c+1
    start = 1'b0;
    chk("c1_busy", busy, 1);
    chk("c1_done", done, 0);
    chk("c1_addr", ram_addr, 0);
    chk("c1_valid", m_valid, 0);
    chk("c1_outstanding", dbg_outstanding, 1);
    tick();                                   // c+2
    chk("c2_valid", m_valid, 0);
    tick();                                   // c+3
    chk("c3_valid", m_valid, 1);
    chk("c3_data", m_data, BASE);
    chk("c3_last", m_last, 0);
  endtask

  // Consume beats starting in the current cycle. pat 0 = m_ready always high,
  // pat 1 = 1,0,0,1,1,0 repeating. Optionally pulses start at beat start_beat.
  task automatic stream_frame(input int pat, input int stop_at, input int start_beat, input int budget);
    int          beat = 0;
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    bit          seen = 1'b0;
    bit          pulsed = 1'b0;
    logic [5:0]  bp = 6'b011001;
    for (int cyc = 0; cyc < budget && beat < stop_at; cyc++) begin
      m_ready = (pat == 0) ? 1'b1 : bp[cyc % 6];
      if (beat == start_beat && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      chk("addr_range", (ram_addr <= 10'd999), 1);
      chk("occupancy", (dbg_outstanding <= 3'd4), 1);
      if (stalled) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held);
      end
      if (pat == 0 && seen) chk("no_bubble", m_valid, 1);
      if (m_valid) begin
        seen = 1'b1;
        chk("m_last", m_last, (beat == N - 1));
      end
      if (m_valid && m_ready) begin
        chk("data", m_data, BASE + 32'(beat));
        beat++;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      tick();
    end
    start = 1'b0;
    chk("beat_count", beat, stop_at);
  endtask

  // Checks for the cycle after the final handshake.
  task automatic check_done();
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", m_valid, 0);
    chk("end_state", dbg_state, ST_DONE);
    tick();
    chk("done_held", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; src_ready = 1'b0; m_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_addr", ram_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outstanding", dbg_outstanding, 0);
    rst = 1'b0;
    tick();

    // 1. Full frame at full rate
    start_head(1'b1);
    stream_frame(0, N, -1, N + 50);
    check_done();

    // 6. start while done -> second frame; start during STREAM is ignored
    start_head(1'b1);
    stream_frame(0, N, 500, N + 50);
    check_done();

    // 2. Backpressure pattern
    start = 1'b1; src_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_done_clear", done, 0);
    stream_frame(1, N, -1, 2500);
    check_done();

    // 3. Stall at start: prefetch fills to exactly four reads (0..3)
    start_head(1'b0);
    repeat (17) tick();                       // c+20
    chk("stall_addr", ram_addr, 3);
    chk("stall_outstanding", dbg_outstanding, 4);
    chk("stall_head", m_data, BASE);
    chk("stall_state", dbg_state, ST_STREAM);
    stream_frame(0, N, -1, N + 50);
    check_done();

    // 4. Source gating: start with src_ready low, src_ready rises at cycle 50
    src_ready = 1'b0; m_ready = 1'b1; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    chk("gate_busy", busy, 1);
    chk("gate_state", dbg_state, ST_WAIT_SRC);
    chk("gate_outstanding", dbg_outstanding, 0);
    repeat (48) tick();                       // cycle 49
    chk("gate_outstanding49", dbg_outstanding, 0);
    chk("gate_addr49", ram_addr, 999);
    tick();                                   // cycle 50
    src_ready = 1'b1;
    tick();                                   // cycle 51
    chk("gate_addr51", ram_addr, 0);
    chk("gate_outstanding51", dbg_outstanding, 1);
    chk("gate_state51", dbg_state, ST_STREAM);
    stream_frame(0, N, -1, N + 50);
    check_done();

    // 5. Reset after beat 500, then a clean frame from mem[0]
    start_head(1'b1);
    stream_frame(0, 501, -1, 600);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_outstanding", dbg_outstanding, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick();
    start_head(1'b1);
    stream_frame(0, N, -1, N + 50);
    check_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
